// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall, bubble and flush handling.
// Define EX_MEM_MADD_EN to build the multiply-accumulate feedback register (hilo/cnt).
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo
`ifdef EX_MEM_MADD_EN
  ,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
`endif
);

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } stage_t;

  typedef enum logic [1:0] {
    EDGE_FLUSH,
    EDGE_BUBBLE,
    EDGE_PASS,
    EDGE_HOLD
  } edge_e;

  edge_e  edge_sel;
  stage_t stage_d, stage_q;

  // Priority: flush beats any stall; only stall[3] and stall[4] matter.
  always_comb begin
    if (flush)
      edge_sel = EDGE_FLUSH;
    else if (!stall[3])
      edge_sel = EDGE_PASS;
    else if (!stall[4])
      edge_sel = EDGE_BUBBLE;
    else
      edge_sel = EDGE_HOLD;
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    stage_d = stage_q;
    unique case (edge_sel)
      EDGE_FLUSH,
      EDGE_BUBBLE: stage_d = '0;
      EDGE_PASS: begin
        stage_d.wd    = ex_wd;
        stage_d.wreg  = ex_wreg;
        stage_d.wdata = ex_wdata;
        stage_d.whilo = ex_whilo;
        stage_d.hi    = ex_hi;
        stage_d.lo    = ex_lo;
      end
      EDGE_HOLD: stage_d = stage_q;
      default:   stage_d = stage_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stage_q <= '0;
    else
      stage_q <= stage_d;
  end

  assign mem_wd    = stage_q.wd;
  assign mem_wreg  = stage_q.wreg;
  assign mem_wdata = stage_q.wdata;
  assign mem_whilo = stage_q.whilo;
  assign mem_hi    = stage_q.hi;
  assign mem_lo    = stage_q.lo;

`ifdef EX_MEM_MADD_EN
  logic [63:0] hilo_d, hilo_q;
  logic [1:0]  cnt_d, cnt_q;

  // The partial product survives only across the bubble of a two-cycle madd/msub.
  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (edge_sel)
      EDGE_FLUSH,
      EDGE_PASS: begin
        hilo_d = '0;
        cnt_d  = '0;
      end
      EDGE_BUBBLE: begin
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      EDGE_HOLD: begin
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
      end
      default: begin
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
`endif

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS32 core. Each rising clock edge it captures the execute-stage results (destination register, write enable, write data, HI/LO update) and presents them to the memory stage. It obeys the pipeline stall vector, inserts bubbles, and honours flush. It also holds the intermediate 64-bit product and cycle count of two-cycle multiply-accumulate instructions (madd/maddu/msub/msubu) and feeds them back to the execute stage.

## Interface
- Parameters: none. Widths come from the shared defines: register 32 bits, register address 5 bits.
- Reset (already decided): one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high (`RstEnable` = 1)
- stall  input  6  pipeline stall vector; bit 3 = execute stalled, bit 4 = memory stalled
- flush  input  1  synchronous pipeline flush
- ex_wd  input  5  destination register address from execute
- ex_wreg  input  1  register write enable from execute
- ex_wdata  input  32  result from execute
- ex_whilo  input  1  HI/LO write enable from execute
- ex_hi, ex_lo  input  32 each  HI/LO values from execute
- hilo_i  input  64  partial multiply-accumulate product from execute
- cnt_i  input  2  multiply-accumulate cycle count from execute
- mem_wd  output  5  registered destination address
- mem_wreg  output  1  registered register write enable
- mem_wdata  output  32  registered result
- mem_whilo  output  1  registered HI/LO write enable
- mem_hi, mem_lo  output  32 each  registered HI/LO values
- hilo_o  output  64  held partial product, returned to execute
- cnt_o  output  2  held cycle count, returned to execute

## Operation
- All outputs are registered. Each edge falls into exactly one of these cases, evaluated in priority order:
  - **RESET** (rst=1, asynchronous): every output = 0 (`ZeroWord`, `NOPRegAddr`, `WriteDisable`).
  - **FLUSH** (flush=1): every output = 0, including hilo_o and cnt_o. This aborts any multiply-accumulate in progress.
  - **BUBBLE** (stall[3]=1, stall[4]=0):
    - mem_* outputs = 0.
    - hilo_o ← hilo_i; cnt_o ← cnt_i.
  - **PASS** (stall[3]=0):
    - mem_* ← ex_*.
    - hilo_o ← 0; cnt_o ← 0.
  - **HOLD** (stall[3]=1, stall[4]=1): all outputs keep their value.
- Multiply-accumulate sequence:
  - Execute cycle 1 requests a stall, drives cnt_i=1 and the product on hilo_i. The register is in BUBBLE, so it captures both.
  - Execute cycle 2 reads hilo_o/cnt_o, drives cnt_i=2 and releases the stall. The register is in PASS, so cnt_o returns to 0.
- No arithmetic is performed; values are copied bit-exact.
- stall bits other than 3 and 4 are ignored.

## Timing
- Latency: one cycle from ex_* to mem_* in PASS.
- Multi-cycle accumulate: hilo_o/cnt_o are valid exactly one cycle after the BUBBLE edge that captured them. They stay valid for as long as HOLD persists.
- The reset assert edge clears outputs immediately, without waiting for clk.
- On reset release, the first clk edge follows the normal case rules.
- flush and stall on the same edge: flush wins.
- A reset in the middle of a multiply-accumulate discards the partial product (cnt_o=0).
- Back-to-back PASS edges carry no dead cycle; throughput is one instruction per cycle.

## Configuration
- Macro: `EX_MEM_MADD_EN`.
- Defined:
  - hilo_i, cnt_i, hilo_o and cnt_o exist.
  - The BUBBLE capture and the hold/flush behaviour described above apply.
- Undefined:
  - The multiply-accumulate ports are omitted and no 66 bits of storage are built.
  - Execute must then implement madd/msub without the two-cycle feedback.
  - All other behaviour is unchanged.

## Test plan
- **Reset:**
  - Stimulus: rst=1 mid-cycle while outputs hold nonzero values.
  - Required response: all outputs become 0 before the next clk edge.
  - After release with stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678: after one edge, mem_wd=5, mem_wreg=1, mem_wdata=0x1234_5678.
- **Bubble:**
  - Stimulus: stall=6'b001111 with ex_wreg=1, ex_wdata=0xFFFF_FFFF.
  - Required response: after one edge, mem_wreg=0 and mem_wdata=0.
- **Hold:**
  - Stimulus: load mem_wdata=0xAAAA_5555, then stall=6'b011111 for 3 edges with ex_wdata=0x1111_1111.
  - Required response: mem_wdata stays 0xAAAA_5555; the next PASS edge loads 0x1111_1111.
- **Multiply-accumulate** (macro defined):
  - Stimulus: BUBBLE edge with hilo_i=0x0000_0001_8000_0000, cnt_i=1.
  - Required response: hilo_o holds that value and cnt_o=1.
  - Following PASS edge (cnt_i=2, ex_whilo=1, ex_hi=1, ex_lo=0x8000_0003): cnt_o=0, hilo_o=0, mem_hi=1, mem_lo=0x8000_0003.
- **Flush with stall:**
  - Stimulus: flush=1 together with stall=6'b001111 and cnt_i=1.
  - Required response: all outputs 0 after the edge, including cnt_o.
- **PASS clears feedback:**
  - Stimulus: with hilo_o nonzero, stall=0.
  - Required response: hilo_o=0 after one edge.
